// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: a length byte, then big-endian words
// written to consecutive word addresses from 0, with the CPU held meanwhile.
module imem_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_cnt;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] n_last;
    logic [23:0]   shift_bytes;
    logic          accept;
    logic          len_zero;
    logic          len_bad;
    logic          word_end;
    logic          mem_we_next;
    logic          err_next;

    // in_ready is registered but always mirrors the current state (LEN/DATA)
    assign accept   = in_valid & in_ready;
    assign len_zero = (in_data == 8'd0);
    assign len_bad  = (32'(in_data) > DEPTH);
    assign word_end = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_we_next = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (len_zero) begin
                        state_next = DONE;
                    end else if (len_bad) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_end) begin
                    mem_we_next = 1'b1;
                    if (word_cnt == n_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word assembly and counters; reset discards any partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= 2'd0;
            word_cnt    <= '0;
            n_last      <= '0;
            shift_bytes <= 24'd0;
        end else begin
            if (state == LEN && accept && !len_zero && !len_bad) begin
                n_last   <= CW'(in_data - 8'd1);
                byte_cnt <= 2'd0;
                word_cnt <= '0;
            end
            if (state == DATA && accept) begin
                shift_bytes <= {shift_bytes[15:0], in_data};
                byte_cnt    <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_cnt <= word_cnt + CW'(1);
                end
            end
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= 32'd0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= (state_next == LEN) || (state_next == DATA);
            busy     <= (state_next != IDLE);
            cpu_hold <= (state_next != IDLE);
            done     <= (state_next == DONE);
            err      <= err_next;
            mem_we   <= mem_we_next;
            if (mem_we_next) begin
                mem_addr <= word_cnt[AW-1:0];
                mem_wd   <= {shift_bytes, in_data};
            end
        end
    end

endmodule
